// File: rtl/clock_pkg.sv
// Shared clock-control definitions: mode state encoding seen by the display logic.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_MIN  = 2'd1,
    MODE_SET_HOUR = 2'd2
  } mode_e;

endpackage

// File: rtl/btn_pulse.sv
// Push-button front end: 2-flop synchronizer, level debounce, rising-edge press pulse.
// Pulse is registered; a button held through reset must be released before it can fire.
module btn_pulse #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);

  logic          sync1;
  logic          sync2;
  logic [1:0]    vld;
  logic          stable;
  logic [CW-1:0] cnt;

  // stable resets high so a press held through reset only ever debounces to a release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      vld    <= 2'b00;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      vld   <= {vld[0], 1'b1};
      press <= 1'b0;
      if (vld[1] && (sync2 != stable)) begin
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          stable <= sync2;
          cnt    <= '0;
          press  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock control: run-mode carry chain on tick_1hz, set-mode field increments from buttons.
// All pulse outputs are registered, one cycle after the qualifying tick or press.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int MIN_MAX      = 59,
  parameter int HOUR_MAX     = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] sec,
  input  logic [6:0] min,
  input  logic [4:0] hour,
  output logic       count_sec,
  output logic       count_min,
  output logic       count_hour,
  output logic       set_min,
  output logic       set_hour,
  output logic       clr_sec,
  output logic       clr_min,
  output logic       clr_hour,
  output logic [1:0] mode,
  output logic       blink
);

  mode_e state, state_nxt;
  logic  mode_press, inc_press;
  logic  c_sec, c_min, c_hour, s_min, s_hour, cl_sec, cl_min, cl_hour, blink_nxt;

  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_mode (
    .clk(clk), .rst_n(rst_n), .btn(btn_mode), .press(mode_press)
  );

  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_inc (
    .clk(clk), .rst_n(rst_n), .btn(btn_inc), .press(inc_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MODE_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mode_press) begin
      case (state)
        MODE_RUN:     state_nxt = MODE_SET_MIN;
        MODE_SET_MIN: state_nxt = MODE_SET_HOUR;
        default:      state_nxt = MODE_RUN;
      endcase
    end
  end

  always_comb begin
    c_sec   = 1'b0;
    c_min   = 1'b0;
    c_hour  = 1'b0;
    s_min   = 1'b0;
    s_hour  = 1'b0;
    cl_sec  = 1'b0;
    cl_min  = 1'b0;
    cl_hour = 1'b0;
    if (state == MODE_RUN && tick_1hz) begin
      if (int'(sec) < MIN_MAX) c_sec = 1'b1;
      else begin
        cl_sec = 1'b1;
        if (int'(min) < MIN_MAX) c_min = 1'b1;
        else begin
          cl_min = 1'b1;
          if (int'(hour) < HOUR_MAX) c_hour = 1'b1;
          else                       cl_hour = 1'b1;
        end
      end
    end
    // leaving RUN clears seconds; the clear overrides a coincident seconds increment
    if (state == MODE_RUN && mode_press) begin
      cl_sec = 1'b1;
      c_sec  = 1'b0;
    end
    if (inc_press && !mode_press) begin
      if (state == MODE_SET_MIN) begin
        if (int'(min) < MIN_MAX) s_min = 1'b1;
        else                     cl_min = 1'b1;
      end else if (state == MODE_SET_HOUR) begin
        if (int'(hour) < HOUR_MAX) s_hour = 1'b1;
        else                       cl_hour = 1'b1;
      end
    end
    if (state_nxt != state || state == MODE_RUN) blink_nxt = 1'b0;
    else if (tick_1hz)                           blink_nxt = ~blink;
    else                                         blink_nxt = blink;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_sec  <= 1'b0;
      count_min  <= 1'b0;
      count_hour <= 1'b0;
      set_min    <= 1'b0;
      set_hour   <= 1'b0;
      clr_sec    <= 1'b0;
      clr_min    <= 1'b0;
      clr_hour   <= 1'b0;
      blink      <= 1'b0;
    end else begin
      count_sec  <= c_sec;
      count_min  <= c_min;
      count_hour <= c_hour;
      set_min    <= s_min;
      set_hour   <= s_hour;
      clr_sec    <= cl_sec;
      clr_min    <= cl_min;
      clr_hour   <= cl_hour;
      blink      <= blink_nxt;
    end
  end

  assign mode = state;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, 4, number of consecutive stable synchronized samples required before a button level is accepted.
REQ-002 SHALL have parameter MIN_MAX, 59, last valid minute and second value before wrap.
REQ-003 SHALL have parameter HOUR_MAX, 23, last valid hour value before wrap.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick_1hz  input  1  one-cycle pulse once per second, synchronous to clk.
REQ-007 SHALL have port btn_mode  input  1  raw asynchronous mode push-button, active-high.
REQ-008 SHALL have port btn_inc  input  1  raw asynchronous increment push-button, active-high.
REQ-009 SHALL have ports sec, min, hour  input  6, 7, 5  current values from the second, minute and hour counters.
REQ-010 SHALL have ports count_sec, count_min, count_hour  output  1 each  one-cycle run-mode increment pulses.
REQ-011 SHALL have ports set_min, set_hour  output  1 each  one-cycle set-mode increment pulses.
REQ-012 SHALL have ports clr_sec, clr_min, clr_hour  output  1 each  one-cycle synchronous-clear pulses to the counters.
REQ-013 SHALL have port mode  output  2  current state: 0 RUN, 1 SET_MIN, 2 SET_HOUR.
REQ-014 SHALL have port blink  output  1  display blink enable for the field being set.

Function
REQ-015 SHALL synchronize each button through two flops, debounce it over DEBOUNCE_CYC samples and emit one single-cycle press pulse per accepted rising edge.
REQ-016 SHALL implement FSM RUN -> SET_MIN -> SET_HOUR -> RUN, advancing one state per btn_mode press pulse.
REQ-017 SHALL, in RUN on tick_1hz, assert count_sec if sec < MIN_MAX, else assert clr_sec and evaluate the minute carry.
REQ-018 SHALL, on minute carry, assert count_min if min < MIN_MAX, else assert clr_min and evaluate the hour carry.
REQ-019 SHALL, on hour carry, assert count_hour if hour < HOUR_MAX, else assert clr_hour.
REQ-020 SHALL, in SET_MIN on btn_inc press, assert set_min if min < MIN_MAX, else assert clr_min, never generating an hour carry.
REQ-021 SHALL, in SET_HOUR on btn_inc press, assert set_hour if hour < HOUR_MAX, else assert clr_hour.
REQ-022 SHALL assert clr_sec for one cycle on the RUN -> SET_MIN transition.
REQ-023 SHALL ignore tick_1hz in SET_MIN and SET_HOUR, and ignore btn_inc in RUN.
REQ-024 SHALL register all pulse outputs, with each pulse appearing exactly one clk cycle after the qualifying tick or press pulse.
REQ-025 SHALL never assert clr_x together with count_x or set_x for the same counter.
REQ-026 SHALL, when press pulses for btn_mode and btn_inc coincide, perform the mode transition and drop the increment.
REQ-027 SHALL, when tick_1hz and a btn_mode press coincide in RUN, process the tick and change state on the same edge.
REQ-028 SHALL hold blink at 0 in RUN and toggle it on each tick_1hz in the set states, clearing it on every state change.

Reset
REQ-029 SHALL, while rst_n is low, force mode to RUN, all pulse outputs and blink to 0, debounce counters to 0 and synchronizers to 0.
REQ-030 SHALL, on reset mid-press, require the button to be released and pressed again before a press pulse is emitted.

Structure
REQ-031 SHALL place the mode state encoding (RUN/SET_MIN/SET_HOUR) in a shared package, clock_pkg, used by the display logic.
REQ-032 SHALL implement synchronize, debounce and edge-detect in one sub-module, btn_pulse, instantiated twice.

Verification
REQ-033 SHALL verify RUN carry chain: sec=59, min=59, hour=23, tick -> clr_sec, clr_min and clr_hour all high one cycle later, with no count pulses.
REQ-034 SHALL verify a plain tick: sec=10, tick -> count_sec only, for exactly one cycle.
REQ-035 SHALL verify mode cycling: three btn_mode presses -> mode 1, 2, 0, with clr_sec pulsed on the first press only.
REQ-036 SHALL verify set wrap: SET_MIN, min=59, btn_inc -> clr_min only, with no count_hour.
REQ-037 SHALL verify bounce rejection: btn_inc toggling every cycle for 3 cycles then held high -> exactly one set pulse.
REQ-038 SHALL verify coincidence: btn_mode and btn_inc pressed together in SET_MIN -> mode=2 and no set_min.
